spm_boot_sequencer: RTL and testbench

//  Boot/run sequencer for the RISC-SPM system. Holds the CPU core in reset and owns the

---
 rtl/spm_boot_sequencer_pkg.sv | 31 +++
 rtl/spm_boot_sequencer_run_timer.sv | 48 ++++
 rtl/spm_boot_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_spm_boot_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/spm_boot_sequencer_pkg.sv
// Shared types and defaults for the RISC-SPM boot/run sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spm_boot_sequencer_pkg;

  // SRAM address/data width and run-timer width defaults
  localparam int unsigned SPM_WORD_SIZE = 8;
  localparam int unsigned SPM_TIMEOUT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } spm_state_e;

  // Externally visible status flags, kept together so they update as one
  typedef struct packed {
    logic busy;
    logic done;
    logic err;
  } spm_status_t;

  // States in which a start request is honoured
  function automatic logic spm_accepts_start(input spm_state_e s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR);
  endfunction

endpackage

// File: rtl/spm_boot_sequencer_run_timer.sv
// Run-cycle counter for the sequencer's RUN phase, with a terminal flag.
// Latency: terminal_o is combinational from the count, asserted in the cycle whose increment reaches all-ones.
// Backpressure: none; counts every enabled cycle.
//
// Ports:
//   clk_i, rst_ni  clock, async active-low reset
//   clear_i        synchronous clear to zero (wins over enable)
//   enable_i       count one per cycle
//   terminal_o     this cycle is the (2^TIMEOUT_W-1)-th enabled cycle since clear
module spm_boot_sequencer_run_timer
  import spm_boot_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_W = SPM_TIMEOUT_W
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic terminal_o
);

  // Count value one below all-ones: the increment out of this value
  // completes the timeout window.
  localparam logic [TIMEOUT_W-1:0] CNT_LAST_M1 = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  logic [TIMEOUT_W-1:0] cnt_q;
  logic [TIMEOUT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign terminal_o = enable_i && !clear_i && (cnt_q == CNT_LAST_M1);

endmodule

// File: rtl/spm_boot_sequencer.sv
// Boot/run sequencer: holds the RISC-SPM core in reset, streams a program from the host into SRAM, then supervises the run.
// Latency: all outputs registered; one word written per accepted transfer, cpu_rst rises two cycles after the last accept.
// Backpressure: in_ready_o is high only in LOAD while words remain; host words outside LOAD are dropped.
//
// Ports:
//   clk_i, rst_ni                      clock, async active-low reset
//   start_i, load_base_i, load_len_i   load+run request; base/len captured on accept
//   in_valid_i, in_data_i, in_ready_o  host word stream (valid/ready)
//   mem_sel_o, mem_addr_o, mem_data_o, mem_write_o   SRAM write port and port-select
//   cpu_rst_o, cpu_halt_i              core reset (active-low) and HALT indication
//   busy_o, done_o, err_o              status
module spm_boot_sequencer
  import spm_boot_sequencer_pkg::*;
#(
  parameter int unsigned WORD_SIZE = SPM_WORD_SIZE,
  parameter int unsigned TIMEOUT_W = SPM_TIMEOUT_W
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [WORD_SIZE-1:0] load_base_i,
  input  logic [WORD_SIZE-1:0] load_len_i,
  input  logic                 in_valid_i,
  input  logic [WORD_SIZE-1:0] in_data_i,
  output logic                 in_ready_o,
  output logic                 mem_sel_o,
  output logic [WORD_SIZE-1:0] mem_addr_o,
  output logic [WORD_SIZE-1:0] mem_data_o,
  output logic                 mem_write_o,
  output logic                 cpu_rst_o,
  input  logic                 cpu_halt_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  spm_state_e           state_q, state_d;
  logic [WORD_SIZE-1:0] ptr_q, ptr_d;
  logic [WORD_SIZE-1:0] rem_q, rem_d;
  logic [WORD_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_SIZE-1:0] mem_data_q, mem_data_d;
  logic                 in_ready_q, in_ready_d;
  logic                 mem_sel_q, mem_sel_d;
  logic                 mem_write_q, mem_write_d;
  logic                 cpu_rst_q, cpu_rst_d;
  spm_status_t          status_q, status_d;

  logic timer_clear;
  logic timer_en;
  logic timer_term;
  logic xfer;

  // The timer is zeroed during the single FLUSH cycle so each run starts
  // its timeout window fresh, regardless of how the previous run ended.
  assign timer_clear = (state_q == ST_FLUSH);
  assign timer_en    = (state_q == ST_RUN);

  spm_boot_sequencer_run_timer #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_run_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (timer_clear),
    .enable_i   (timer_en),
    .terminal_o (timer_term)
  );

  // in_ready_q is only ever high in LOAD, so this is the whole handshake.
  assign xfer = in_valid_i && in_ready_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rem_d       = rem_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    in_ready_d  = in_ready_q;
    mem_sel_d   = mem_sel_q;
    mem_write_d = 1'b0;          // strobe lasts exactly one cycle per word
    cpu_rst_d   = cpu_rst_q;
    status_d    = status_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_i && spm_accepts_start(state_q)) begin
          ptr_d         = load_base_i;
          rem_d         = load_len_i;
          cpu_rst_d     = 1'b0;
          status_d.busy = 1'b1;
          status_d.done = 1'b0;
          status_d.err  = 1'b0;
          if (load_len_i != '0) begin
            state_d    = ST_LOAD;
            mem_sel_d  = 1'b1;
            in_ready_d = 1'b1;
          end else begin
            // Nothing to load: go straight through FLUSH to release the core
            state_d = ST_FLUSH;
          end
        end
      end

      ST_LOAD: begin
        if (xfer) begin
          mem_addr_d  = ptr_q;
          mem_data_d  = in_data_i;
          mem_write_d = 1'b1;
          ptr_d       = ptr_q + WORD_SIZE'(1);   // wraps past the top of SRAM
          rem_d       = rem_q - WORD_SIZE'(1);
          if (rem_q == WORD_SIZE'(1)) begin
            in_ready_d = 1'b0;
            state_d    = ST_FLUSH;
          end
        end
      end

      ST_FLUSH: begin
        // The last write strobe is on the port during this cycle with
        // mem_sel still high; the port is handed to the CPU only after it.
        mem_sel_d = 1'b0;
        cpu_rst_d = 1'b1;
        state_d   = ST_RUN;
      end

      ST_RUN: begin
        // A HALT seen in the final timeout cycle still counts as success
        if (cpu_halt_i) begin
          state_d       = ST_DONE;
          cpu_rst_d     = 1'b0;
          status_d.busy = 1'b0;
          status_d.done = 1'b1;
        end else if (timer_term) begin
          state_d       = ST_ERR;
          cpu_rst_d     = 1'b0;
          status_d.busy = 1'b0;
          status_d.err  = 1'b1;
        end
      end

      default: begin
        state_d       = ST_IDLE;
        in_ready_d    = 1'b0;
        mem_sel_d     = 1'b0;
        cpu_rst_d     = 1'b0;
        status_d      = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      rem_q       <= '0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      in_ready_q  <= 1'b0;
      mem_sel_q   <= 1'b0;
      mem_write_q <= 1'b0;
      cpu_rst_q   <= 1'b0;
      status_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      in_ready_q  <= in_ready_d;
      mem_sel_q   <= mem_sel_d;
      mem_write_q <= mem_write_d;
      cpu_rst_q   <= cpu_rst_d;
      status_q    <= status_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign mem_sel_o   = mem_sel_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_data_o  = mem_data_q;
  assign mem_write_o = mem_write_q;
  assign cpu_rst_o   = cpu_rst_q;
  assign busy_o      = status_q.busy;
  assign done_o      = status_q.done;
  assign err_o       = status_q.err;

endmodule

// File: tb/tb_spm_boot_sequencer.sv
// Directed bench for spm_boot_sequencer: load, wrap, gapped input, zero-length, halt, timeout, reset abort.
// Two instances share stimulus: default timer width, and a 4-bit timer for timeout cases.
// Flag vectors are {in_ready, mem_sel, mem_write, cpu_rst, busy, done, err}.
module tb_spm_boot_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] load_base;
  logic [7:0] load_len;
  logic       in_valid;
  logic [7:0] in_data;
  logic       cpu_halt;

  logic       in_ready, mem_sel, mem_write, cpu_rst, busy, done, err;
  logic [7:0] mem_addr, mem_data;
  logic       in_ready_t, mem_sel_t, mem_write_t, cpu_rst_t, busy_t, done_t, err_t;
  logic [7:0] mem_addr_t, mem_data_t;

  logic [6:0] flags, flags_t;
  assign flags   = {in_ready, mem_sel, mem_write, cpu_rst, busy, done, err};
  assign flags_t = {in_ready_t, mem_sel_t, mem_write_t, cpu_rst_t, busy_t, done_t, err_t};

  int checks = 0;
  int errors = 0;

  spm_boot_sequencer dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .load_base_i(load_base),
    .load_len_i(load_len), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready), .mem_sel_o(mem_sel), .mem_addr_o(mem_addr),
    .mem_data_o(mem_data), .mem_write_o(mem_write), .cpu_rst_o(cpu_rst),
    .cpu_halt_i(cpu_halt), .busy_o(busy), .done_o(done), .err_o(err)
  );

  spm_boot_sequencer #(.WORD_SIZE(8), .TIMEOUT_W(4)) dut_t (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .load_base_i(load_base),
    .load_len_i(load_len), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready_t), .mem_sel_o(mem_sel_t), .mem_addr_o(mem_addr_t),
    .mem_data_o(mem_data_t), .mem_write_o(mem_write_t), .cpu_rst_o(cpu_rst_t),
    .cpu_halt_i(cpu_halt), .busy_o(busy_t), .done_o(done_t), .err_o(err_t)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock; inputs changed afterwards are sampled at the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (flags !== 7'b0000000) begin errors++; $display("FAIL reset_flags got %b exp 0000000", flags); end
    checks++; if (mem_addr !== 8'h00 || mem_data !== 8'h00) begin errors++; $display("FAIL reset_bus got %h/%h exp 00/00", mem_addr, mem_data); end
    checks++; if (flags_t !== 7'b0000000) begin errors++; $display("FAIL reset_flags_t got %b exp 0000000", flags_t); end
    rst_n = 1'b1;
    step();
    checks++; if (flags !== 7'b0000000) begin errors++; $display("FAIL idle_flags got %b exp 0000000", flags); end
  endtask

  // base 10, len 3, AA/BB/CC back-to-back; then halt in RUN cycle 20.
  // The 4-bit-timer instance times out after 15 RUN cycles meanwhile.
  task automatic test_load_halt_timeout();
    start = 1'b1; load_base = 8'h10; load_len = 8'd3;
    step();
    start = 1'b0;
    checks++; if (flags !== 7'b1100100) begin errors++; $display("FAIL load_enter got %b exp 1100100", flags); end
    in_valid = 1'b1; in_data = 8'hAA;
    step();
    checks++; if (flags !== 7'b1110100 || mem_addr !== 8'h10 || mem_data !== 8'hAA) begin errors++; $display("FAIL wr0 got %b %h/%h exp 1110100 10/AA", flags, mem_addr, mem_data); end
    in_data = 8'hBB;
    step();
    checks++; if (flags !== 7'b1110100 || mem_addr !== 8'h11 || mem_data !== 8'hBB) begin errors++; $display("FAIL wr1 got %b %h/%h exp 1110100 11/BB", flags, mem_addr, mem_data); end
    in_data = 8'hCC;
    step();
    checks++; if (flags !== 7'b0110100 || mem_addr !== 8'h12 || mem_data !== 8'hCC) begin errors++; $display("FAIL wr2 got %b %h/%h exp 0110100 12/CC", flags, mem_addr, mem_data); end
    in_valid = 1'b0;
    step();
    checks++; if (flags !== 7'b0001100) begin errors++; $display("FAIL run_enter got %b exp 0001100", flags); end
    for (int k = 1; k <= 19; k++) begin
      step();
      if (k == 14) begin
        checks++; if (flags_t !== 7'b0001100) begin errors++; $display("FAIL tmo_early got %b exp 0001100", flags_t); end
      end
      if (k == 15) begin
        checks++; if (flags_t !== 7'b0000001) begin errors++; $display("FAIL tmo_err got %b exp 0000001", flags_t); end
      end
    end
    checks++; if (flags !== 7'b0001100) begin errors++; $display("FAIL run_c19 got %b exp 0001100", flags); end
    cpu_halt = 1'b1;
    step();
    cpu_halt = 1'b0;
    checks++; if (flags !== 7'b0000010) begin errors++; $display("FAIL halt_done got %b exp 0000010", flags); end
    checks++; if (flags_t !== 7'b0000001) begin errors++; $display("FAIL err_hold got %b exp 0000001", flags_t); end
    step();
    checks++; if (flags !== 7'b0000010) begin errors++; $display("FAIL done_hold got %b exp 0000010", flags); end
  endtask

  // Restart from DONE/ERR; halt lands in the same cycle as the 4-bit timeout.
  task automatic test_reload_same_cycle_halt();
    start = 1'b1; load_base = 8'h20; load_len = 8'd2;
    step();
    start = 1'b0;
    checks++; if (flags !== 7'b1100100) begin errors++; $display("FAIL reload_enter got %b exp 1100100", flags); end
    checks++; if (flags_t !== 7'b1100100) begin errors++; $display("FAIL reload_enter_t got %b exp 1100100", flags_t); end
    in_valid = 1'b1; in_data = 8'h11;
    step();
    checks++; if (flags !== 7'b1110100 || mem_addr !== 8'h20 || mem_data !== 8'h11) begin errors++; $display("FAIL reload_wr0 got %b %h/%h exp 1110100 20/11", flags, mem_addr, mem_data); end
    in_data = 8'h22;
    step();
    checks++; if (flags !== 7'b0110100 || mem_addr !== 8'h21 || mem_data !== 8'h22) begin errors++; $display("FAIL reload_wr1 got %b %h/%h exp 0110100 21/22", flags, mem_addr, mem_data); end
    in_valid = 1'b0;
    step();
    for (int k = 1; k <= 14; k++) step();
    checks++; if (flags_t !== 7'b0001100) begin errors++; $display("FAIL pre_tmo got %b exp 0001100", flags_t); end
    cpu_halt = 1'b1;
    step();
    cpu_halt = 1'b0;
    checks++; if (flags_t !== 7'b0000010) begin errors++; $display("FAIL halt_vs_tmo got %b exp 0000010", flags_t); end
    checks++; if (flags !== 7'b0000010) begin errors++; $display("FAIL reload_done got %b exp 0000010", flags); end
  endtask

  // base FE, len 3, valid every other cycle: FE, FF, 00 with in_ready held.
  task automatic test_wrap_gapped();
    start = 1'b1; load_base = 8'hFE; load_len = 8'd3;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'h5A;
    step();
    checks++; if (flags !== 7'b1110100 || mem_addr !== 8'hFE || mem_data !== 8'h5A) begin errors++; $display("FAIL wrap_wr0 got %b %h/%h exp 1110100 FE/5A", flags, mem_addr, mem_data); end
    in_valid = 1'b0;
    step();
    checks++; if (flags !== 7'b1100100) begin errors++; $display("FAIL wrap_gap0 got %b exp 1100100", flags); end
    in_valid = 1'b1; in_data = 8'hA5;
    step();
    checks++; if (flags !== 7'b1110100 || mem_addr !== 8'hFF || mem_data !== 8'hA5) begin errors++; $display("FAIL wrap_wr1 got %b %h/%h exp 1110100 FF/A5", flags, mem_addr, mem_data); end
    in_valid = 1'b0;
    step();
    checks++; if (flags !== 7'b1100100) begin errors++; $display("FAIL wrap_gap1 got %b exp 1100100", flags); end
    in_valid = 1'b1; in_data = 8'h3C;
    step();
    checks++; if (flags !== 7'b0110100 || mem_addr !== 8'h00 || mem_data !== 8'h3C) begin errors++; $display("FAIL wrap_wr2 got %b %h/%h exp 0110100 00/3C", flags, mem_addr, mem_data); end
    in_valid = 1'b0;
    step();
    checks++; if (flags !== 7'b0001100) begin errors++; $display("FAIL wrap_run got %b exp 0001100", flags); end
    cpu_halt = 1'b1;
    step();
    cpu_halt = 1'b0;
    checks++; if (flags !== 7'b0000010) begin errors++; $display("FAIL wrap_done got %b exp 0000010", flags); end
  endtask

  // len 0 with host valid held high: no writes anywhere; start in RUN ignored.
  task automatic test_len_zero();
    in_valid = 1'b1; in_data = 8'hEE;
    step();
    checks++; if (flags !== 7'b0000010) begin errors++; $display("FAIL drop_in_done got %b exp 0000010", flags); end
    start = 1'b1; load_base = 8'h70; load_len = 8'd0;
    step();
    start = 1'b0;
    checks++; if (flags !== 7'b0000100) begin errors++; $display("FAIL len0_flush got %b exp 0000100", flags); end
    step();
    checks++; if (flags !== 7'b0001100) begin errors++; $display("FAIL len0_run got %b exp 0001100", flags); end
    start = 1'b1; load_base = 8'h40; load_len = 8'd5;
    step();
    start = 1'b0;
    checks++; if (flags !== 7'b0001100) begin errors++; $display("FAIL start_in_run got %b exp 0001100", flags); end
    in_valid = 1'b0;
    cpu_halt = 1'b1;
    step();
    cpu_halt = 1'b0;
    checks++; if (flags !== 7'b0000010) begin errors++; $display("FAIL len0_done got %b exp 0000010", flags); end
  endtask

  // Abort after 2 of 5 words, then a fresh 1-word load must start cleanly.
  task automatic test_reset_mid_load();
    start = 1'b1; load_base = 8'h30; load_len = 8'd5;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'h01;
    step();
    in_data = 8'h02;
    step();
    in_valid = 1'b0;
    checks++; if (flags !== 7'b1110100 || mem_addr !== 8'h31 || mem_data !== 8'h02) begin errors++; $display("FAIL mid_wr1 got %b %h/%h exp 1110100 31/02", flags, mem_addr, mem_data); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (flags !== 7'b0000000 || mem_addr !== 8'h00 || mem_data !== 8'h00) begin errors++; $display("FAIL abort_async got %b %h/%h exp 0000000 00/00", flags, mem_addr, mem_data); end
    step();
    rst_n = 1'b1;
    step();
    checks++; if (flags !== 7'b0000000) begin errors++; $display("FAIL abort_idle got %b exp 0000000", flags); end
    start = 1'b1; load_base = 8'h50; load_len = 8'd1;
    step();
    start = 1'b0;
    checks++; if (flags !== 7'b1100100) begin errors++; $display("FAIL fresh_enter got %b exp 1100100", flags); end
    in_valid = 1'b1; in_data = 8'h77;
    step();
    in_valid = 1'b0;
    checks++; if (flags !== 7'b0110100 || mem_addr !== 8'h50 || mem_data !== 8'h77) begin errors++; $display("FAIL fresh_wr got %b %h/%h exp 0110100 50/77", flags, mem_addr, mem_data); end
    step();
    checks++; if (flags !== 7'b0001100) begin errors++; $display("FAIL fresh_run got %b exp 0001100", flags); end
    cpu_halt = 1'b1;
    step();
    cpu_halt = 1'b0;
    checks++; if (flags !== 7'b0000010) begin errors++; $display("FAIL fresh_done got %b exp 0000010", flags); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; load_base = 8'h00; load_len = 8'h00;
    in_valid = 1'b0; in_data = 8'h00; cpu_halt = 1'b0;
    test_reset();
    test_load_halt_timeout();
    test_reload_same_cycle_halt();
    test_wrap_gapped();
    test_len_zero();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
